dm_cache_ctrl: RTL and testbench
================================

Name: dm_cache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate cache controller that sits directly upstream of the byte-addressed main memory.
- Serves byte reads and writes from the CPU side.
- Read misses fetch a 4-byte block from memory; every write is forwarded to memory.
- Hit and miss counters are kept for lab measurement.

Parameters:
- ADDR_W, 10, byte address width; equals the memory AddressBus width.
- NUM_LINES, 8, number of cache lines; power of 2. Index width IDX_W = log2(NUM_LINES).
- CNT_W, 16, width of the hit/miss counters.
- Block size is fixed at 4 bytes: offset = addr[1:0], index = addr[IDX_W+1:2], tag = addr[ADDR_W-1:IDX_W+2] (5 bits at defaults).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- cpu_req  in  1  request valid; sampled only while cpu_busy=0.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  8  write byte.
- cpu_rdata  out  8  read byte; valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_hit  out  1  qualifies cpu_ready: 1=request hit.
- cpu_busy  out  1  high whenever state != IDLE.
- cache_read_req_to_mem  out  1  block read request to memory.
- cache_write_req_to_mem  out  1  byte write request to memory.
- AddressBus  out  ADDR_W  memory address.
- dInputBus  out  8  memory write byte.
- dOutputBus  in  32  memory read block, big-endian: [31:24] is byte at AddressBus+0.
- memoryRR  in  1  memory read ready.
- memoryWR  in  1  memory write ready.
- hit_count  out  CNT_W  saturating hit counter.
- miss_count  out  CNT_W  saturating miss counter.

Behaviour:
- Storage per line:
  - valid bit
  - tag
  - 32-bit data word, byte k at bits [31-8k -: 8]
- Reset (synchronous, rst=1 at posedge):
  - all valid bits = 0
  - state = IDLE
  - all outputs = 0, including counters, AddressBus and dInputBus
  - any in-flight memory request is abandoned; request lines drop the next cycle
  - data and tag arrays need no reset
- States: IDLE, RD_MEM, WR_MEM, RESP.
- IDLE:
  - On cpu_req=1, latch addr, we and wdata.
  - Compare tag against the indexed line; hit = valid && tag match.
  - Read hit: latch the byte into cpu_rdata, set hit flag, go to RESP. No memory access.
  - Read miss: AddressBus = {addr[ADDR_W-1:2], 2'b00}, assert cache_read_req_to_mem, go to RD_MEM.
  - Write (hit or miss): AddressBus = cpu_addr, dInputBus = cpu_wdata, assert cache_write_req_to_mem, go to WR_MEM.
    - On a write hit, the line byte is updated in the same edge.
    - A write miss leaves the cache untouched.
- RD_MEM:
  - Hold the request and address stable until memoryRR=1 is sampled.
  - Then write dOutputBus into the line, set valid and tag, drive cpu_rdata from the offset byte, drop the request, go to RESP.
- WR_MEM:
  - Hold the request until memoryWR=1 is sampled.
  - Then drop the request and go to RESP.
- RESP:
  - cpu_ready=1 and cpu_hit = latched hit flag for exactly one cycle, then return to IDLE.
  - memoryRR and memoryWR are ignored in RESP. Memory holds its ready for one extra cycle after the request drops, and RESP absorbs that stale ready.
- Latency, from the accept edge to the cpu_ready cycle:
  - read hit: 1 cycle
  - read miss or write: 3 cycles against the 1-cycle memory (request edge, memory ready edge, capture edge)
- Counters:
  - Read hit: hit_count+1.
  - Write hit: hit_count+1.
  - Read miss: miss_count+1.
  - Write miss: miss_count+1.
  - Each increments on the accept edge and saturates at all-ones.
- cpu_req while busy is ignored, not queued.
- Memory ready seen outside the matching wait state is ignored.
- Both memory requests are never high simultaneously.
- Read miss to a valid line: the line is overwritten (eviction needs no writeback).

Test Plan:
- Reset, then read 0x004 with memory block 0x004..0x007 = AA,BB,CC,DD:
  - cache_read_req_to_mem=1 with AddressBus=0x004
  - 3 cycles later cpu_ready=1, cpu_hit=0, cpu_rdata=0xAA
  - miss_count=1
- Then read 0x006:
  - cpu_ready 1 cycle after accept, cpu_hit=1, cpu_rdata=0xCC
  - no memory request
  - hit_count=1
- Write 0x005 data 0x55 (hit):
  - cache_write_req_to_mem with AddressBus=0x005, dInputBus=0x55
  - cpu_ready after memoryWR, cpu_hit=1
  - subsequent read 0x005 hits with 0x55
- Conflict: read 0x024, which shares index 1 with 0x004:
  - miss; line refilled
  - a following read of 0x004 misses again, miss_count=3
- Assert rst while in RD_MEM:
  - next cycle state=IDLE, request low, counters=0
  - stale memoryRR ignored
  - a prior hit address now misses
- Hold cpu_req=1 for 3 cycles during a miss:
  - only one request is accepted
  - counters increment once
  - cpu_ready pulses exactly once

Source files
------------

// File: rtl/dm_cache_ctrl_if.sv
// Purpose: CPU-side and memory-side signal bundle for the direct-mapped cache controller.
// Ports: cpu_* carry request/response; cache_*_req_to_mem, AddressBus, dInputBus,
//        dOutputBus, memoryRR, memoryWR form the byte-addressed memory bus.
//        slave = controller view, master = environment (CPU + memory) view.
interface dm_cache_ctrl_if #(
   parameter int ADDR_W = 10
) ();
   // CPU side
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [7:0]        cpu_wdata;
   logic [7:0]        cpu_rdata;
   logic              cpu_ready;
   logic              cpu_hit;
   logic              cpu_busy;
   // Memory side
   logic              cache_read_req_to_mem;
   logic              cache_write_req_to_mem;
   logic [ADDR_W-1:0] AddressBus;
   logic [7:0]        dInputBus;
   logic [31:0]       dOutputBus;
   logic              memoryRR;
   logic              memoryWR;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  dOutputBus, memoryRR, memoryWR,
      output cpu_rdata, cpu_ready, cpu_hit, cpu_busy,
      output cache_read_req_to_mem, cache_write_req_to_mem, AddressBus, dInputBus
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output dOutputBus, memoryRR, memoryWR,
      input  cpu_rdata, cpu_ready, cpu_hit, cpu_busy,
      input  cache_read_req_to_mem, cache_write_req_to_mem, AddressBus, dInputBus
   );
endinterface

// File: rtl/dm_cache_ctrl.sv
// Purpose: direct-mapped, write-through, no-write-allocate byte cache with 4-byte lines.
// Latency: read hit -> cpu_ready 1 cycle after accept; read miss / write -> 3 cycles with 1-cycle memory.
// Backpressure: one request at a time; cpu_req is ignored (not queued) while cpu_busy=1.
// Ports: clk, rst (sync, active-high); bus (dm_cache_ctrl_if.slave) for CPU and memory
//        signals; hit_count / miss_count are saturating lab counters.
module dm_cache_ctrl #(
   parameter int ADDR_W    = 10,
   parameter int NUM_LINES = 8,
   parameter int CNT_W     = 16
) (
   input  logic                clk,
   input  logic                rst,
   dm_cache_ctrl_if.slave      bus,
   output logic [CNT_W-1:0]    hit_count,
   output logic [CNT_W-1:0]    miss_count
);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = ADDR_W - IDX_W - 2;

   typedef enum logic [1:0] {IDLE, RD_MEM, WR_MEM, RESP} state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [ADDR_W-1:0]  abus_q, abus_d;
   logic [7:0]         din_q, din_d;
   logic [7:0]         rdata_q, rdata_d;
   logic               hit_q, hit_d;
   logic               rd_req_q, rd_req_d;
   logic               wr_req_q, wr_req_d;
   logic [CNT_W-1:0]   hcnt_q, hcnt_d;
   logic [CNT_W-1:0]   mcnt_q, mcnt_d;

   // Line storage; only valid bits need a reset.
   logic [NUM_LINES-1:0] valid_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [31:0]          data_q [NUM_LINES];

   // Lookup on the incoming request
   logic [IDX_W-1:0] req_idx;
   logic [TAG_W-1:0] req_tag;
   logic [1:0]       req_off;
   logic             req_hit;
   // Refill target taken from the latched address
   logic [IDX_W-1:0] fill_idx;
   logic [TAG_W-1:0] fill_tag;
   logic             fill_en;
   logic             wbyte_en;

   assign req_idx  = bus.cpu_addr[IDX_W+1:2];
   assign req_tag  = bus.cpu_addr[ADDR_W-1:IDX_W+2];
   assign req_off  = bus.cpu_addr[1:0];
   assign req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign fill_idx = addr_q[IDX_W+1:2];
   assign fill_tag = addr_q[ADDR_W-1:IDX_W+2];

   // Big-endian byte select: offset 0 is the most significant byte.
   function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] off);
      logic [7:0] b;
      case (off)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      abus_d   = abus_q;
      din_d    = din_q;
      rdata_d  = rdata_q;
      hit_d    = hit_q;
      rd_req_d = rd_req_q;
      wr_req_d = wr_req_q;
      hcnt_d   = hcnt_q;
      mcnt_d   = mcnt_q;
      fill_en  = 1'b0;
      wbyte_en = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.cpu_req) begin
               addr_d = bus.cpu_addr;
               hit_d  = req_hit;
               if (req_hit) hcnt_d = (hcnt_q == '1) ? hcnt_q : hcnt_q + 1'b1;
               else         mcnt_d = (mcnt_q == '1) ? mcnt_q : mcnt_q + 1'b1;

               if (bus.cpu_we) begin
                  // Write-through: always forwarded; a hit also patches the line now.
                  abus_d   = bus.cpu_addr;
                  din_d    = bus.cpu_wdata;
                  wr_req_d = 1'b1;
                  wbyte_en = req_hit;
                  state_d  = WR_MEM;
               end else if (req_hit) begin
                  rdata_d = pick_byte(data_q[req_idx], req_off);
                  state_d = RESP;
               end else begin
                  abus_d   = {bus.cpu_addr[ADDR_W-1:2], 2'b00};
                  rd_req_d = 1'b1;
                  state_d  = RD_MEM;
               end
            end
         end
         RD_MEM: begin
            if (bus.memoryRR) begin
               fill_en  = 1'b1;
               rdata_d  = pick_byte(bus.dOutputBus, addr_q[1:0]);
               rd_req_d = 1'b0;
               state_d  = RESP;
            end
         end
         WR_MEM: begin
            if (bus.memoryWR) begin
               wr_req_d = 1'b0;
               state_d  = RESP;
            end
         end
         RESP: begin
            // Memory ready lingers one cycle after the request drops; it is ignored here.
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (rst) begin
         fill_en  = 1'b0;
         wbyte_en = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         abus_q   <= '0;
         din_q    <= '0;
         rdata_q  <= '0;
         hit_q    <= 1'b0;
         rd_req_q <= 1'b0;
         wr_req_q <= 1'b0;
         hcnt_q   <= '0;
         mcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         abus_q   <= abus_d;
         din_q    <= din_d;
         rdata_q  <= rdata_d;
         hit_q    <= hit_d;
         rd_req_q <= rd_req_d;
         wr_req_q <= wr_req_d;
         hcnt_q   <= hcnt_d;
         mcnt_q   <= mcnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (fill_en) begin
         valid_q[fill_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (fill_en) begin
         data_q[fill_idx] <= bus.dOutputBus;
         tag_q[fill_idx]  <= fill_tag;
      end else if (wbyte_en) begin
         case (req_off)
            2'd0:    data_q[req_idx][31:24] <= bus.cpu_wdata;
            2'd1:    data_q[req_idx][23:16] <= bus.cpu_wdata;
            2'd2:    data_q[req_idx][15:8]  <= bus.cpu_wdata;
            default: data_q[req_idx][7:0]   <= bus.cpu_wdata;
         endcase
      end
   end

   assign bus.cpu_rdata              = rdata_q;
   assign bus.cpu_ready              = (state_q == RESP);
   assign bus.cpu_hit                = (state_q == RESP) && hit_q;
   assign bus.cpu_busy               = (state_q != IDLE);
   assign bus.cache_read_req_to_mem  = rd_req_q;
   assign bus.cache_write_req_to_mem = wr_req_q;
   assign bus.AddressBus             = abus_q;
   assign bus.dInputBus              = din_q;
   assign hit_count                  = hcnt_q;
   assign miss_count                 = mcnt_q;
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Purpose: self-checking bench for dm_cache_ctrl: 1-cycle memory model, directed scenarios,
//          randomized traffic checked every cycle against a block-level cache model.
// Ports: none (top-level bench); counters narrowed so saturation is reached.
module tb_dm_cache_ctrl;
   localparam int ADDR_W    = 10;
   localparam int NUM_LINES = 8;
   localparam int CNT_W     = 6;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dm_cache_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
   logic [CNT_W-1:0] hit_count, miss_count;

   dm_cache_ctrl #(.ADDR_W(ADDR_W), .NUM_LINES(NUM_LINES), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .bus(bus), .hit_count(hit_count), .miss_count(miss_count)
   );

   // ---------------- memory: ready one cycle after request, held one cycle after drop
   logic [7:0] mem     [1024];
   logic [7:0] ref_mem [1024];
   logic [ADDR_W-1:0] mblk;
   always @(posedge clk) begin
      mblk = {bus.AddressBus[ADDR_W-1:2], 2'b00};
      bus.memoryRR   <= bus.cache_read_req_to_mem;
      bus.memoryWR   <= bus.cache_write_req_to_mem;
      bus.dOutputBus <= {mem[mblk], mem[mblk + 10'd1], mem[mblk + 10'd2], mem[mblk + 10'd3]};
      if (bus.cache_write_req_to_mem) mem[bus.AddressBus] <= bus.dInputBus;
   end

   // ---------------- bookkeeping
   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input longint act_v, input longint exp_v);
      total++;
      if (act_v != exp_v) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act_v, exp_v, $time);
      end
   endtask

   function automatic int sat(input int v);
      return (v > CNT_MAX) ? CNT_MAX : v;
   endfunction

   // ---------------- behavioural model: which 4-byte block each line holds
   int line_blk [NUM_LINES];
   int m_hits, m_miss;

   task automatic model_reset();
      for (int i = 0; i < NUM_LINES; i++) line_blk[i] = -1;
      m_hits = 0;
      m_miss = 0;
   endtask

   // ---------------- expectation of the transaction in flight
   bit         chk_en = 1'b0;
   bit         act    = 1'b0;
   int         k      = 0;
   int         e_lat;
   bit         e_hit, e_rd, e_rreq, e_wreq;
   logic [9:0] e_abus;
   logic [7:0] e_din, e_rdata;
   // Observed values, for the literal checks
   logic [7:0] o_rdata, o_din;
   logic [9:0] o_abus;
   bit         o_hit, o_sawreq;
   int         o_lat;
   int         ready_pulses = 0;

   // ---------------- single per-cycle compare process
   always @(negedge clk) begin
      if (chk_en) begin
         if (act) k++;
         chk("both_req", int'(bus.cache_read_req_to_mem & bus.cache_write_req_to_mem), 0);
         chk("busy", bus.cpu_busy, act);
         chk("ready", bus.cpu_ready, act && (k == e_lat));
         chk("rd_req", bus.cache_read_req_to_mem, act && e_rreq && (k < e_lat));
         chk("wr_req", bus.cache_write_req_to_mem, act && e_wreq && (k < e_lat));
         chk("hit_count", hit_count, sat(m_hits));
         chk("miss_count", miss_count, sat(m_miss));
         if (act && (e_rreq || e_wreq) && (k < e_lat)) begin
            chk("addr_bus", bus.AddressBus, e_abus);
            if (e_wreq) chk("din_bus", bus.dInputBus, e_din);
         end
         if (bus.cache_read_req_to_mem || bus.cache_write_req_to_mem) begin
            o_abus   = bus.AddressBus;
            o_din    = bus.dInputBus;
            o_sawreq = 1'b1;
         end
         if (bus.cpu_ready) begin
            ready_pulses++;
            o_hit   = bus.cpu_hit;
            o_rdata = bus.cpu_rdata;
            o_lat   = k;
         end
         if (act && (k == e_lat)) begin
            chk("cpu_hit", bus.cpu_hit, e_hit);
            if (e_rd) chk("cpu_rdata", bus.cpu_rdata, e_rdata);
            act = 1'b0;
         end
      end
   end

   // ---------------- one CPU request; hold = cycles cpu_req stays high
   task automatic op(input logic we, input logic [9:0] a, input logic [7:0] wd, input int hold);
      int idx, blk, n;
      bit h;
      idx = int'(a[4:2]);
      blk = int'(a[9:2]);
      h   = (line_blk[idx] == blk);
      @(negedge clk);
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_addr  = a;
      bus.cpu_wdata = wd;
      @(posedge clk);
      #1;
      e_hit   = h;
      e_rd    = !we;
      e_rreq  = !we && !h;
      e_wreq  = we;
      e_lat   = (!we && h) ? 1 : 3;
      e_abus  = we ? a : {a[9:2], 2'b00};
      e_din   = wd;
      e_rdata = ref_mem[a];
      if (h) m_hits++; else m_miss++;
      if (we) ref_mem[a] = wd;
      else if (!h) line_blk[idx] = blk;
      o_sawreq = 1'b0;
      k   = 0;
      act = 1'b1;
      for (int i = 1; i < hold; i++) begin
         @(posedge clk);
         #1;
      end
      bus.cpu_req = 1'b0;
      n = 0;
      while (act && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("op_timeout", act, 0);
      act = 1'b0;
   endtask

   initial begin
      int pulses0;
      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      for (int i = 0; i < 1024; i++) begin
         mem[i]     = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      mem[4] = 8'hAA; mem[5] = 8'hBB; mem[6] = 8'hCC; mem[7] = 8'hDD;
      ref_mem[4] = 8'hAA; ref_mem[5] = 8'hBB; ref_mem[6] = 8'hCC; ref_mem[7] = 8'hDD;
      model_reset();

      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", bus.cpu_ready, 0);
      chk("rst_busy", bus.cpu_busy, 0);
      chk("rst_hit", bus.cpu_hit, 0);
      chk("rst_rdreq", bus.cache_read_req_to_mem, 0);
      chk("rst_wrreq", bus.cache_write_req_to_mem, 0);
      chk("rst_abus", bus.AddressBus, 0);
      chk("rst_din", bus.dInputBus, 0);
      chk("rst_rdata", bus.cpu_rdata, 0);
      chk("rst_hcnt", hit_count, 0);
      chk("rst_mcnt", miss_count, 0);
      rst = 1'b0;
      chk_en = 1'b1;

      // Cold read miss
      op(1'b0, 10'h004, 8'h00, 1);
      chk("tp_miss_abus", o_abus, 10'h004);
      chk("tp_miss_lat", o_lat, 3);
      chk("tp_miss_hit", o_hit, 0);
      chk("tp_miss_rdata", o_rdata, 8'hAA);
      chk("tp_miss_cnt", miss_count, 1);

      // Read hit in the same block
      op(1'b0, 10'h006, 8'h00, 1);
      chk("tp_hit_lat", o_lat, 1);
      chk("tp_hit_hit", o_hit, 1);
      chk("tp_hit_rdata", o_rdata, 8'hCC);
      chk("tp_hit_noreq", o_sawreq, 0);
      chk("tp_hit_cnt", hit_count, 1);

      // Write hit, then read back
      op(1'b1, 10'h005, 8'h55, 1);
      chk("tp_wr_abus", o_abus, 10'h005);
      chk("tp_wr_din", o_din, 8'h55);
      chk("tp_wr_hit", o_hit, 1);
      op(1'b0, 10'h005, 8'h00, 1);
      chk("tp_wrrd_hit", o_hit, 1);
      chk("tp_wrrd_rdata", o_rdata, 8'h55);

      // Conflict on index 1
      op(1'b0, 10'h024, 8'h00, 1);
      chk("tp_conf_hit", o_hit, 0);
      op(1'b0, 10'h004, 8'h00, 1);
      chk("tp_conf_rehit", o_hit, 0);
      chk("tp_conf_mcnt", miss_count, 3);

      // cpu_req held through a miss: accepted once
      pulses0 = ready_pulses;
      op(1'b0, 10'h100, 8'h00, 3);
      repeat (3) @(negedge clk);
      chk("tp_hold_pulses", ready_pulses - pulses0, 1);
      chk("tp_hold_mcnt", miss_count, 4);

      // Reset while waiting on memory
      chk_en = 1'b0;
      @(negedge clk);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 10'h204;
      @(posedge clk);
      #1;
      bus.cpu_req = 1'b0;
      chk("tp_rst_inflight", bus.cache_read_req_to_mem, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("tp_rst_busy", bus.cpu_busy, 0);
      chk("tp_rst_rdreq", bus.cache_read_req_to_mem, 0);
      chk("tp_rst_hcnt", hit_count, 0);
      chk("tp_rst_mcnt", miss_count, 0);
      model_reset();
      @(posedge clk);
      #1;
      chk("tp_stale_busy", bus.cpu_busy, 0);
      chk("tp_stale_ready", bus.cpu_ready, 0);
      chk_en = 1'b1;
      op(1'b0, 10'h006, 8'h00, 1);
      chk("tp_rst_prevhit", o_hit, 0);

      // Randomized traffic over few tags so hits, conflicts and saturation all occur
      for (int i = 0; i < 600; i++) begin
         logic [9:0] a;
         logic       we;
         int         hold;
         bit         h;
         a = 10'($urandom_range(0, 63));
         if ($urandom_range(0, 9) == 0) a[9:5] = 5'($urandom);
         we = ($urandom_range(0, 9) < 3);
         h  = (line_blk[int'(a[4:2])] == int'(a[9:2]));
         hold = (we || !h) ? int'($urandom_range(1, 3)) : 1;
         op(we, a, 8'($urandom), hold);
      end
      repeat (2) @(negedge clk);
      chk("sat_hits", hit_count, CNT_MAX);
      chk("sat_miss", miss_count, CNT_MAX);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
